onehot_pulse_decoder: RTL and testbench

- Sequential N-to-2^N decoder, the inverse of the team's 4-to-2 priority encoder.
- Accepts an encoded index over a valid/ready handshake and drives the matching one-hot output line.
- The line is held for a fixed number of cycles, followed by a programmable all-zero gap.
- Sits downstream of encoder-produced codes and drives strobe/select lines that need a minimum pulse width and a clean deassertion between pulses.

---
 rtl/onehot_pulse_decoder.sv | 113 +++++++++++
 tb/tb_onehot_pulse_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - sequential code-to-one-hot decoder with fixed pulse width and programmable gap
module onehot_pulse_decoder #(
    parameter int CODE_W = 2,
    parameter int HOLD   = 4,
    parameter int GAP    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      code,
    output logic [2**CODE_W-1:0]   y,
    output logic                   y_valid,
    output logic [CODE_W-1:0]      last_code,
    output logic                   busy
);

    localparam int OUT_W   = 2**CODE_W;
    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reload values: counters run down to zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_y;
    logic               r_y_valid;
    logic [CODE_W-1:0]  r_last_code;
    logic               r_busy;

    logic               w_accept;
    logic               w_cnt_zero;
    logic [OUT_W-1:0]   w_onehot;

    // Ready is combinational so a rising enable is honoured in the same cycle.
    assign in_ready   = (r_state == S_IDLE) && en;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_onehot   = {{(OUT_W-1){1'b0}}, 1'b1} << code;

    assign y         = r_y;
    assign y_valid   = r_y_valid;
    assign last_code = r_last_code;
    assign busy      = r_busy;

    // Pulse sequencer: IDLE -> DRIVE for HOLD cycles -> GAP for GAP cycles -> IDLE, outputs registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_last_code <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_DRIVE;
                        r_cnt       <= HOLD_LOAD;
                        r_last_code <= code;
                        r_y         <= w_onehot;
                        r_y_valid   <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    // Normal end and an enable abort share one exit path, so coinciding events behave identically.
                    if (w_cnt_zero || !en) begin
                        r_y       <= '0;
                        r_y_valid <= 1'b0;
                        if (GAP == 0) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= GAP_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    // The gap always runs to completion regardless of enable.
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - scoreboard bench for onehot_pulse_decoder in two parameterisations
module tb_onehot_pulse_decoder;

    localparam int CW     = 2;
    localparam int OW     = 4;
    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 0;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] code     = '0;

    logic          rdy [2];
    logic [OW-1:0] yo  [2];
    logic          yvo [2];
    logic [CW-1:0] lco [2];
    logic          bzo [2];

    onehot_pulse_decoder #(.CODE_W(CW), .HOLD(HOLD_A), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[0]),
        .code(code), .y(yo[0]), .y_valid(yvo[0]), .last_code(lco[0]), .busy(bzo[0])
    );

    onehot_pulse_decoder #(.CODE_W(CW), .HOLD(HOLD_B), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[1]),
        .code(code), .y(yo[1]), .y_valid(yvo[1]), .last_code(lco[1]), .busy(bzo[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] code;
        int            width;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Reference model: each accepted code is a time window. Edge index k; pulse visible after edges [acc, pend),
    // block busy after edges [acc, idle_at), ready again once k >= idle_at.
    int hp [2] = '{HOLD_A, HOLD_B};
    int gp [2] = '{GAP_A, GAP_B};
    int k = 0;
    int acc     [2];
    int pend    [2];
    int idle_at [2];
    logic [CW-1:0] m_last [2];
    exp_t e;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                acc[i] = -10; pend[i] = -10; idle_at[i] = -10; m_last[i] = '0;
            end
            q0.delete();
            q1.delete();
        end else begin
            k++;
            for (int i = 0; i < 2; i++) begin
                if (en && in_valid && (k - 1) >= idle_at[i]) begin
                    acc[i]     = k;
                    pend[i]    = k + hp[i];
                    idle_at[i] = k + hp[i] + gp[i];
                    m_last[i]  = code;
                    e.code     = code;
                    e.width    = hp[i];
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                end else if (!en && acc[i] < k && k < pend[i]) begin
                    pend[i]    = k;
                    idle_at[i] = k + gp[i];
                    if (i == 0) begin
                        e = q0[q0.size()-1]; e.width = k - acc[i]; q0[q0.size()-1] = e;
                    end else begin
                        e = q1[q1.size()-1]; e.width = k - acc[i]; q1[q1.size()-1] = e;
                    end
                end
            end
        end
    end

    // Per-cycle output check plus pulse monitor popping the scoreboard when a pulse ends.
    logic [OW-1:0] ey;
    logic          mon_on [2] = '{1'b0, 1'b0};
    logic [OW-1:0] mon_y  [2];
    int            mon_w  [2] = '{0, 0};
    exp_t          got;
    logic          have;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mon_on[i] = 1'b0;
                mon_w[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ey = (acc[i] <= k && k < pend[i]) ? (OW'(1) << m_last[i]) : '0;
                check("y",         i, 32'(yo[i]),  32'(ey));
                check("y_valid",   i, 32'(yvo[i]), 32'(ey != '0));
                check("busy",      i, 32'(bzo[i]), 32'(k < idle_at[i]));
                check("in_ready",  i, 32'(rdy[i]), 32'(en && k >= idle_at[i]));
                check("last_code", i, 32'(lco[i]), 32'(m_last[i]));
                if (yvo[i]) begin
                    if (!mon_on[i]) begin
                        mon_on[i] = 1'b1;
                        mon_y[i]  = yo[i];
                        mon_w[i]  = 0;
                    end
                    mon_w[i]++;
                end else if (mon_on[i]) begin
                    mon_on[i] = 1'b0;
                    have = 1'b0;
                    if (i == 0 && q0.size() > 0) begin got = q0.pop_front(); have = 1'b1; end
                    if (i == 1 && q1.size() > 0) begin got = q1.pop_front(); have = 1'b1; end
                    check("sb_nonempty", i, 32'(have), 32'd1);
                    if (have) begin
                        check("sb_pulse", i, 32'(mon_y[i]), 32'(OW'(1) << got.code));
                        check("sb_width", i, 32'(mon_w[i]), 32'(got.width));
                    end
                end
            end
        end
    end

    task automatic drive(input logic e_i, input logic v_i, input logic [CW-1:0] c_i, input int n);
        en       = e_i;
        in_valid = v_i;
        code     = c_i;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 3);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, '0, 2);

        // Basic decode of code 3.
        drive(1'b1, 1'b1, 2'd3, 1);
        drive(1'b1, 1'b0, '0, 8);

        // Back-to-back with code changing every cycle.
        for (int j = 0; j < 24; j++) drive(1'b1, 1'b1, CW'(j % 3), 1);
        drive(1'b1, 1'b0, '0, 8);

        // Abort on the second drive cycle.
        drive(1'b1, 1'b1, 2'd1, 1);
        drive(1'b1, 1'b0, '0, 1);
        drive(1'b0, 1'b0, '0, 5);
        drive(1'b1, 1'b0, '0, 4);

        // Enable gating with a pending request.
        drive(1'b0, 1'b1, 2'd2, 10);
        drive(1'b1, 1'b1, 2'd2, 1);
        drive(1'b1, 1'b0, '0, 8);

        // Asynchronous reset mid-pulse.
        drive(1'b1, 1'b1, 2'd2, 1);
        drive(1'b1, 1'b0, '0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_y",       0, 32'(yo[0]),  32'd0);
        check("rst_y_valid", 0, 32'(yvo[0]), 32'd0);
        check("rst_busy",    0, 32'(bzo[0]), 32'd0);
        check("rst_last",    0, 32'(lco[0]), 32'd0);
        drive(1'b1, 1'b0, '0, 2);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 0, 32'(rdy[0]), 32'd1);
        check("rst_ready", 1, 32'(rdy[1]), 32'd1);
        drive(1'b1, 1'b0, '0, 2);

        // Randomised traffic.
        for (int j = 0; j < 1500; j++)
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0), CW'($urandom), 1);

        drive(1'b1, 1'b0, '0, 20);
        check("sb_drain", 0, 32'(q0.size()), 32'd0);
        check("sb_drain", 1, 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
